obi_sram_target: RTL and testbench

- OBI responder (target) for the CB-heep bus.
- Terminates obi_req_t from an initiator or from a pipeline register slice and answers with obi_resp_t.
- Fronts an internal word-addressed, byte-writable storage array.
- Programmable grant wait states let benches and integration exercise initiator-side stalls and outstanding-read handling across pipelined OBI paths.

---
 rtl/obi_pkg.sv | 18 +
 rtl/obi_sram_bank.sv | 31 +++
 rtl/obi_sram_target.sv | 113 +++++++++++
 tb/tb_obi_sram_target.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/obi_pkg.sv
// OBI bus types shared across the CB-heep interconnect.
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/obi_sram_bank.sv
// Byte-writable, word-addressed synchronous single-port storage array.
// Contents are never reset; rdata is updated only by a read access.
module obi_sram_bank #(
  parameter int NumWords = 1024,
  parameter int AddrW    = $clog2(NumWords)
) (
  input  logic             clk_i,
  input  logic             req_i,
  input  logic             we_i,
  input  logic [3:0]       be_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem [NumWords];

  // Byte-masked write and registered read on an accepted access.
  always_ff @(posedge clk_i) begin
    if (req_i) begin
      if (we_i) begin
        for (int b = 0; b < 4; b++) begin
          if (be_i[b]) mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end else begin
        rdata_o <= mem[addr_i];
      end
    end
  end

endmodule

// File: rtl/obi_sram_target.sv
// OBI responder fronting an internal SRAM bank, with programmable grant
// wait states and a single-entry response stage (rvalid one cycle after
// every handshake).
module obi_sram_target
  import obi_pkg::*;
#(
  parameter int NumWords   = 1024,
  parameter int GntLatency = 0
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  obi_req_t  obi_req_i,
  output obi_resp_t obi_resp_o
);

  localparam int AddrW = $clog2(NumWords);
  localparam logic [3:0] Lat = 4'(GntLatency);

  typedef enum logic {IDLE, WAIT} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        gnt;
  logic        hs;
  logic        vld_p1;
  logic        rsp_wr_p1;
  logic [31:0] bank_rdata;
  logic        unused_addr_bits;

  // Byte offset and bits above the array size alias silently.
  assign unused_addr_bits = ^{obi_req_i.addr[31:AddrW+2], obi_req_i.addr[1:0]};

  assign hs = obi_req_i.req & gnt;

  // Grant FSM state and wait counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Count wait cycles while req is held; a dropped req abandons the attempt.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (GntLatency != 0) begin
      case (state_q)
        IDLE: begin
          if (obi_req_i.req) begin
            state_d = WAIT;
            cnt_d   = 4'd1;
          end
        end
        WAIT: begin
          if (!obi_req_i.req || cnt_q == Lat) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Grant: pass-through with no latency, otherwise once the count reaches it.
  always_comb begin
    gnt = 1'b0;
    if (GntLatency == 0) gnt = obi_req_i.req;
    else                 gnt = obi_req_i.req && (state_q == WAIT) && (cnt_q == Lat);
  end

  // ---- stage p0 -> p1: handshake accepted, response issued next cycle ----
  // rsp_wr_p1 resets high so rdata reads as zero out of reset and after writes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1    <= 1'b0;
      rsp_wr_p1 <= 1'b1;
    end else begin
      vld_p1 <= hs;
      if (hs) rsp_wr_p1 <= obi_req_i.we;
    end
  end

  obi_sram_bank #(
    .NumWords (NumWords),
    .AddrW    (AddrW)
  ) u_bank (
    .clk_i   (clk_i),
    .req_i   (hs),
    .we_i    (obi_req_i.we),
    .be_i    (obi_req_i.be),
    .addr_i  (obi_req_i.addr[AddrW+1:2]),
    .wdata_i (obi_req_i.wdata),
    .rdata_o (bank_rdata)
  );

  // Write responses return zero; read data holds in the bank until the next read.
  always_comb begin
    obi_resp_o.gnt    = gnt;
    obi_resp_o.rvalid = vld_p1;
    obi_resp_o.rdata  = rsp_wr_p1 ? 32'h0 : bank_rdata;
  end

endmodule

// File: tb/tb_obi_sram_target.sv
// Directed bench for obi_sram_target: a zero-latency instance driven from a
// vector table and a three-wait-state instance driven by hand sequences.
module tb_obi_sram_target;
  import obi_pkg::*;

  logic      clk;
  logic      rst_ni;
  obi_req_t  req0, req3;
  obi_resp_t rsp0, rsp3;

  int errors = 0;
  int checks = 0;

  obi_sram_target #(.NumWords(1024), .GntLatency(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_ni), .obi_req_i(req0), .obi_resp_o(rsp0));

  obi_sram_target #(.NumWords(1024), .GntLatency(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_ni), .obi_req_i(req3), .obi_resp_o(rsp3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One zero-latency transaction: gnt in the request cycle, response next cycle.
  task automatic txn0(input logic we, input logic [3:0] be, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp, input string tag);
    @(negedge clk);
    req0.req = 1'b1; req0.we = we; req0.be = be; req0.addr = addr; req0.wdata = wdata;
    #1 chk({tag, " gnt"}, 32'(rsp0.gnt), 32'd1);
    @(negedge clk);
    req0.req = 1'b0;
    #1 chk({tag, " rvalid"}, 32'(rsp0.rvalid), 32'd1);
    chk({tag, " rdata"}, rsp0.rdata, exp);
  endtask

  // One latency-3 transaction; reports the request cycle on which gnt appeared.
  task automatic txn3(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp, input string tag);
    int cyc;
    cyc = 0;
    @(negedge clk);
    req3.req = 1'b1; req3.we = we; req3.be = 4'hF; req3.addr = addr; req3.wdata = wdata;
    for (int c = 1; c <= 20; c++) begin
      #1;
      if (rsp3.gnt) begin
        cyc = c;
        break;
      end
      @(negedge clk);
    end
    chk({tag, " gnt cycle"}, 32'(cyc), 32'd4);
    @(negedge clk);
    req3.req = 1'b0;
    #1 chk({tag, " rvalid"}, 32'(rsp3.rvalid), 32'd1);
    chk({tag, " rdata"}, rsp3.rdata, exp);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0};
    vecs[1]  = '{1'b0, 4'hF, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 4'hF, 32'h0000_0020, 32'h1122_3344, 32'h0};
    vecs[3]  = '{1'b1, 4'h5, 32'h0000_0020, 32'hAABB_CCDD, 32'h0};
    vecs[4]  = '{1'b0, 4'hF, 32'h0000_0020, 32'h0,         32'h11BB_33DD};
    vecs[5]  = '{1'b1, 4'hF, 32'h0000_0004, 32'hCAFE_F00D, 32'h0};
    vecs[6]  = '{1'b0, 4'hF, 32'h0000_1004, 32'h0,         32'hCAFE_F00D};
    vecs[7]  = '{1'b1, 4'h0, 32'h0000_0010, 32'hFFFF_FFFF, 32'h0};
    vecs[8]  = '{1'b0, 4'hF, 32'h0000_0013, 32'h0,         32'hDEAD_BEEF};
    vecs[9]  = '{1'b1, 4'hF, 32'h0000_0000, 32'h0A0B_0C0D, 32'h0};
    vecs[10] = '{1'b1, 4'hF, 32'hFFFF_F008, 32'h8080_8080, 32'h0};
    vecs[11] = '{1'b0, 4'hF, 32'h0000_0008, 32'h0,         32'h8080_8080};

    req0 = '0;
    req3 = '0;
    rst_ni = 1'b1;
    #2 rst_ni = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset gnt0",    32'(rsp0.gnt),    32'd0);
    chk("reset rvalid0", 32'(rsp0.rvalid), 32'd0);
    chk("reset rdata0",  rsp0.rdata,       32'h0);
    chk("reset rvalid3", 32'(rsp3.rvalid), 32'd0);
    chk("reset rdata3",  rsp3.rdata,       32'h0);
    @(negedge clk);
    rst_ni = 1'b1;

    for (int i = 0; i < 12; i++) begin
      txn0(vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata, vecs[i].exp,
           $sformatf("vec%0d", i));
    end

    // Response holds its data once rvalid falls.
    @(negedge clk);
    #1;
    chk("hold rvalid", 32'(rsp0.rvalid), 32'd0);
    chk("hold rdata",  rsp0.rdata,       32'h8080_8080);

    // Back-to-back reads at 0x0, 0x4, 0x8.
    begin
      logic [31:0] exp_b2b [3];
      exp_b2b[0] = 32'h0A0B_0C0D;
      exp_b2b[1] = 32'hCAFE_F00D;
      exp_b2b[2] = 32'h8080_8080;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (i < 3) begin
          req0.req = 1'b1; req0.we = 1'b0; req0.be = 4'hF; req0.addr = 32'(i * 4);
        end else begin
          req0.req = 1'b0;
        end
        #1;
        if (i < 3) chk($sformatf("b2b gnt%0d", i), 32'(rsp0.gnt), 32'd1);
        if (i > 0) begin
          chk($sformatf("b2b rvalid%0d", i - 1), 32'(rsp0.rvalid), 32'd1);
          chk($sformatf("b2b rdata%0d", i - 1), rsp0.rdata, exp_b2b[i - 1]);
        end
      end
      @(negedge clk);
      #1 chk("b2b rvalid end", 32'(rsp0.rvalid), 32'd0);
    end

    // Latency 3: write, then reads with req held through two handshakes.
    txn3(1'b1, 32'h0000_0010, 32'h1234_5678, 32'h0, "lat3 wr");
    @(negedge clk);
    req3.req = 1'b1; req3.we = 1'b0; req3.be = 4'hF; req3.addr = 32'h0000_0010;
    for (int c = 1; c <= 9; c++) begin
      #1;
      chk($sformatf("lat3 gnt c%0d", c), 32'(rsp3.gnt), 32'((c == 4) || (c == 8)));
      chk($sformatf("lat3 rvalid c%0d", c), 32'(rsp3.rvalid), 32'((c == 5) || (c == 9)));
      if (c == 5 || c == 9) chk($sformatf("lat3 rdata c%0d", c), rsp3.rdata, 32'h1234_5678);
      @(negedge clk);
    end
    req3.req = 1'b0;

    // Latency 3: req dropped before gnt yields no grant, no response, no write.
    @(negedge clk);
    req3.req = 1'b1; req3.we = 1'b1; req3.be = 4'hF; req3.addr = 32'h0000_0010;
    req3.wdata = 32'hBADB_AD00;
    for (int c = 1; c <= 2; c++) begin
      #1 chk($sformatf("drop gnt c%0d", c), 32'(rsp3.gnt), 32'd0);
      @(negedge clk);
    end
    req3.req = 1'b0;
    #1 chk("drop gnt c3", 32'(rsp3.gnt), 32'd0);
    @(negedge clk);
    #1 chk("drop rvalid", 32'(rsp3.rvalid), 32'd0);
    txn3(1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, "drop rd");

    // Reset in the cycle after a read handshake drops the pending response.
    @(negedge clk);
    req0.req = 1'b1; req0.we = 1'b0; req0.be = 4'hF; req0.addr = 32'h0000_0020;
    @(posedge clk);
    #1;
    rst_ni = 1'b0;
    req0.req = 1'b0;
    #1;
    chk("rst mid rvalid", 32'(rsp0.rvalid), 32'd0);
    chk("rst mid gnt",    32'(rsp0.gnt),    32'd0);
    chk("rst mid rdata",  rsp0.rdata,       32'h0);
    @(negedge clk);
    #1 chk("rst hold rvalid", 32'(rsp0.rvalid), 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    txn0(1'b0, 4'hF, 32'h0000_0020, 32'h0, 32'h11BB_33DD, "post rst rd");
    txn3(1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, "post rst rd3");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
